z80_vram_snoop: RTL and testbench

- Upstream stage of the VGA framebuffer: passively snoops the Z80 memory bus, detects completed memory writes to the ZX display file and attribute area (0x4000–0x5AFF), and emits them as offset-addressed write requests.
- Async bus inputs are synchronised into the CLK domain. Qualified writes are buffered in a small FIFO and drained over a valid/ready interface into the framebuffer's write port.

---
 rtl/z80_vram_snoop.sv | 141 ++++++++++++++
 tb/tb_z80_vram_snoop.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/z80_vram_snoop.sv
// z80_vram_snoop: passive Z80 memory-bus snooper for the VGA framebuffer.
// Synchronises the async Z80 bus into CLK. It detects falling edges of /WR
// during memory cycles. Writes that land in BASE_ADDR..TOP_ADDR are queued in a
// first-word-fall-through FIFO as offset-addressed requests.
// Ports:
//   CLK, RST            clock, async active-low reset
//   A, D, MRQ, WR       async Z80 address/data bus, /MREQ and /WR (active-low)
//   wr_valid/wr_ready   FIFO head handshake; wr_addr/wr_data carry the head entry
//   overflow, clr_ovf   sticky drop flag and its synchronous clear
//   write_count         number of requests pushed, wraps at 2^16
module z80_vram_snoop #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter logic [15:0] TOP_ADDR    = 16'h5AFF,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        MRQ,
  input  logic        WR,
  output logic        wr_valid,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ready,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [15:0] write_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = 26;
  // Sync word layout: {A, D, MRQ, WR}. Strobes reset to their inactive level.
  localparam logic [SW-1:0] SyncRst = {16'h0000, 8'h00, 1'b1, 1'b1};

  // Input synchronisers.
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = {A, D, MRQ, WR};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  logic [15:0] a_s;
  logic [7:0]  d_s;
  logic        mrq_s, wr_s;
  assign {a_s, d_s, mrq_s, wr_s} = sync_q[SYNC_STAGES-1];

  // Strobe detect. prime_q counts edges until the synced stage holds a real
  // sample. Until then wr_prev is held at 0. A /WR that is already low when
  // reset is released is therefore never seen as a falling edge.
  logic [2:0] prime_q, prime_d;
  logic       prime_done;
  logic       wr_prev_q, wr_prev_d;
  logic       wr_event, in_range, accept;
  logic [15:0] a_off;

  assign prime_done = (prime_q == 3'(SYNC_STAGES));
  assign wr_event   = wr_prev_q & ~wr_s & ~mrq_s;
  assign in_range   = (a_s >= BASE_ADDR) && (a_s <= TOP_ADDR);
  assign accept     = wr_event & in_range;
  assign a_off      = a_s - BASE_ADDR;

  // Registered push request (one cycle after detection).
  logic        push_q, push_d;
  logic [12:0] push_addr_q, push_addr_d;
  logic [7:0]  push_data_q, push_data_d;

  always_comb begin
    prime_d     = prime_done ? prime_q : prime_q + 3'd1;
    wr_prev_d   = prime_done ? wr_s : 1'b0;
    push_d      = accept;
    push_addr_d = accept ? a_off[12:0] : push_addr_q;
    push_data_d = accept ? d_s : push_data_q;
  end

  // FIFO. Pointers carry an extra wrap bit so that full and empty differ.
  logic [20:0] mem_q [FIFO_DEPTH];
  logic [20:0] mem_d [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, occ;
  logic        full, pop, push_ok, drop;
  logic        overflow_q, overflow_d;
  logic [15:0] count_q, count_d;

  assign occ      = wptr_q - rptr_q;
  assign full     = (occ == (AW+1)'(FIFO_DEPTH));
  assign wr_valid = (occ != '0);
  assign pop      = wr_valid & wr_ready;
  // A pop in the same cycle frees the slot that a push into a full FIFO needs.
  assign push_ok  = push_q & (~full | pop);
  assign drop     = push_q & full & ~pop;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = {push_addr_q, push_data_q};
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    // A drop takes priority over a clear in the same cycle.
    overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
    count_d    = push_ok ? count_q + 16'd1 : count_q;
  end

  assign {wr_addr, wr_data} = mem_q[rptr_q[AW-1:0]];
  assign overflow           = overflow_q;
  assign write_count        = count_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SyncRst;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      prime_q     <= '0;
      wr_prev_q   <= 1'b0;
      push_q      <= 1'b0;
      push_addr_q <= '0;
      push_data_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      sync_q      <= sync_d;
      mem_q       <= mem_d;
      prime_q     <= prime_d;
      wr_prev_q   <= wr_prev_d;
      push_q      <= push_d;
      push_addr_q <= push_addr_d;
      push_data_q <= push_data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_z80_vram_snoop.sv
// Directed self-checking bench for z80_vram_snoop with default parameters.
module tb_z80_vram_snoop;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] A = 16'h0;
  logic [7:0]  D = 8'h0;
  logic        MRQ = 1'b1;
  logic        WR = 1'b1;
  logic        wr_valid;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready = 1'b0;
  logic        overflow;
  logic        clr_ovf = 1'b0;
  logic [15:0] write_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_count = 16'd0;

  z80_vram_snoop dut (
    .CLK(CLK), .RST(RST), .A(A), .D(D), .MRQ(MRQ), .WR(WR),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .overflow(overflow), .clr_ovf(clr_ovf), .write_count(write_count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One Z80 write cycle: /WR low for 'low' clocks, then idle long enough to push.
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                           input logic mrq, input int low);
    A = addr; D = data; MRQ = mrq; WR = 1'b0;
    cycles(low);
    WR = 1'b1; MRQ = 1'b1;
    cycles(6);
  endtask

  task automatic pop_one();
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", wr_valid); end
    n_tests++; if (wr_addr !== 13'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", wr_addr); end
    n_tests++; if (wr_data !== 8'h0) begin n_fail++; $display("FAIL rst_data got %h exp 0", wr_data); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    n_tests++; if (write_count !== 16'h0) begin n_fail++; $display("FAIL rst_count got %h exp 0", write_count); end
  endtask

  task automatic test_single_write();
    A = 16'h4000; D = 8'hA5; MRQ = 1'b0; WR = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      n_tests++;
      if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early edge %0d got %b exp 0", e, wr_valid); end
    end
    step();
    n_tests++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL lat_edge4 got %b exp 1", wr_valid); end
    cycles(6);
    WR = 1'b1; MRQ = 1'b1;
    cycles(6);
    exp_count = exp_count + 16'd1;
    n_tests++; if (wr_addr !== 13'h0000) begin n_fail++; $display("FAIL single_addr got %h exp 0000", wr_addr); end
    n_tests++; if (wr_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", wr_data); end
    n_tests++; if (write_count !== exp_count) begin n_fail++; $display("FAIL single_count got %0d exp %0d", write_count, exp_count); end
    pop_one();
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_once got %b exp 0", wr_valid); end
  endtask

  task automatic test_boundary();
    bus_write(16'h3FFF, 8'h11, 1'b0, 3);
    bus_write(16'h4000, 8'h22, 1'b0, 3);
    bus_write(16'h5AFF, 8'h33, 1'b0, 3);
    bus_write(16'h5B00, 8'h44, 1'b0, 3);
    exp_count = exp_count + 16'd2;
    n_tests++; if (write_count !== exp_count) begin n_fail++; $display("FAIL bnd_count got %0d exp %0d", write_count, exp_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bnd_ovf got %b exp 0", overflow); end
    n_tests++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 13'h0000, 8'h22}) begin
      n_fail++; $display("FAIL bnd_first got v%b %h/%h exp v1 0000/22", wr_valid, wr_addr, wr_data); end
    pop_one();
    n_tests++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 13'h1AFF, 8'h33}) begin
      n_fail++; $display("FAIL bnd_second got v%b %h/%h exp v1 1aff/33", wr_valid, wr_addr, wr_data); end
    pop_one();
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL bnd_empty got %b exp 0", wr_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) bus_write(16'h5800 + 16'(i), 8'(i + 1), 1'b0, 3);
    exp_count = exp_count + 16'd4;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got %b exp 1", overflow); end
    n_tests++; if (write_count !== exp_count) begin n_fail++; $display("FAIL bp_count got %0d exp %0d", write_count, exp_count); end
    // Head must hold steady while stalled.
    cycles(3);
    n_tests++; if ({wr_addr, wr_data} !== {13'h1800, 8'h01}) begin
      n_fail++; $display("FAIL bp_stable got %h/%h exp 1800/01", wr_addr, wr_data); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, 13'h1800 + 13'(i), 8'(i + 1)}) begin
        n_fail++;
        $display("FAIL bp_pop%0d got v%b %h/%h exp v1 %h/%h", i, wr_valid, wr_addr, wr_data,
                 13'h1800 + 13'(i), 8'(i + 1));
      end
      pop_one();
    end
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", wr_valid); end
  endtask

  task automatic test_non_memory();
    // Popping an empty FIFO must not move pointers.
    pop_one();
    bus_write(16'h4100, 8'h5A, 1'b1, 3);
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL nm_valid got %b exp 0", wr_valid); end
    n_tests++; if (write_count !== exp_count) begin n_fail++; $display("FAIL nm_count got %0d exp %0d", write_count, exp_count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL nm_ovf_kept got %b exp 1", overflow); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL nm_clr got %b exp 0", overflow); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) bus_write(16'h4000 + 16'(i), 8'h10 + 8'(i), 1'b0, 3);
    // Fifth write: pop exactly in the cycle the push reaches the full FIFO.
    A = 16'h4004; D = 8'h14; MRQ = 1'b0; WR = 1'b0;
    cycles(3);
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    cycles(2);
    WR = 1'b1; MRQ = 1'b1;
    cycles(6);
    exp_count = exp_count + 16'd5;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_ovf got %b exp 0", overflow); end
    n_tests++; if (write_count !== exp_count) begin n_fail++; $display("FAIL fp_count got %0d exp %0d", write_count, exp_count); end
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, 13'(i), 8'h10 + 8'(i)}) begin
        n_fail++;
        $display("FAIL fp_pop%0d got v%b %h/%h exp v1 %h/%h", i, wr_valid, wr_addr, wr_data,
                 13'(i), 8'h10 + 8'(i));
      end
      pop_one();
    end
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL fp_empty got %b exp 0", wr_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) bus_write(16'h4010 + 16'(i), 8'h60 + 8'(i), 1'b0, 3);
    A = 16'h4020; D = 8'h77; MRQ = 1'b0; WR = 1'b0;
    cycles(2);
    #2 RST = 1'b0;
    #1;
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", wr_valid); end
    n_tests++; if (write_count !== 16'h0) begin n_fail++; $display("FAIL rm_count got %0d exp 0", write_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rm_ovf got %b exp 0", overflow); end
    cycles(2);
    #2 RST = 1'b1;
    exp_count = 16'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_false_edge cyc %0d got %b exp 0", i, wr_valid); end
    end
    n_tests++; if (write_count !== 16'h0) begin n_fail++; $display("FAIL rm_count_hold got %0d exp 0", write_count); end
    WR = 1'b1;
    cycles(4);
    bus_write(16'h4020, 8'h77, 1'b0, 3);
    n_tests++; if ({wr_valid, wr_addr, wr_data, write_count} !== {1'b1, 13'h0020, 8'h77, 16'd1}) begin
      n_fail++; $display("FAIL rm_next got v%b %h/%h c%0d exp v1 0020/77 c1", wr_valid, wr_addr, wr_data, write_count); end
  endtask

  initial begin
    cycles(3);
    RST = 1'b1;
    cycles(5);
    test_reset();
    test_single_write();
    test_boundary();
    test_backpressure();
    test_non_memory();
    test_full_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
